// File: rtl/poly_accum_if.sv
// Command and adder bus of poly_accum_ctrl.
// slave = controller view; master = Kyber control FSM plus arithmetic datapath view.
`ifndef KYBER_N
`define KYBER_N 256
`endif

interface poly_accum_if #(
  parameter int NUM_SRC = 4,
  parameter int POLY_W  = `KYBER_N*12
);
  logic               start;
  logic [NUM_SRC-1:0] src_mask;
  logic [NUM_SRC-1:0] sub_mask;
  logic [1:0]         mux_sel;
  logic               add_req;
  logic               add_sub;
  logic [POLY_W-1:0]  add_a;
  logic               add_ack;
  logic [POLY_W-1:0]  add_result;
  logic [POLY_W-1:0]  acc_out;
  logic               busy;
  logic               done;
  logic               err;

  modport slave (
    input  start, src_mask, sub_mask, add_ack, add_result,
    output mux_sel, add_req, add_sub, add_a, acc_out, busy, done, err
  );

  modport master (
    output start, src_mask, sub_mask, add_ack, add_result,
    input  mux_sel, add_req, add_sub, add_a, acc_out, busy, done, err
  );
endinterface

// File: rtl/poly_accum_ctrl.sv
// Sequencer for the shared polynomial add/sub datapath: walks a source mask, one adder op per source.
// Optional watchdog abort per adder operation: define ACC_TIMEOUT_EN.
`ifndef KYBER_N
`define KYBER_N 256
`endif

module poly_accum_ctrl #(
  parameter int NUM_SRC        = 4,
  parameter int POLY_W         = `KYBER_N*12,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  poly_accum_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  if (NUM_SRC > 4 || NUM_SRC < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("poly_accum_ctrl: NUM_SRC must be 1..4 and TIMEOUT_CYCLES >= 1");
  end

  logic [1:0]         state;
  logic [NUM_SRC-1:0] rem_mask;
  logic [NUM_SRC-1:0] sub_l;
  logic               empty_l;
  logic [POLY_W-1:0]  acc;
  logic [1:0]         mux_sel_q;
  logic               add_sub_q;
  logic [1:0]         idx;
  logic               issue;

  // Lowest set bit of rem_mask wins.
  always_comb begin
    // NOTE: default assignment first so no path leaves idx unassigned (no latch).
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (rem_mask[i]) idx = 2'(i);
    end
  end

  assign issue = (state == SCAN) && (rem_mask != '0);

  // Selector and op are presented during the request cycle itself so the adder can
  // capture its operands together with add_req; the registered copy holds them in WAIT.
  assign bus.add_req = issue;
  assign bus.mux_sel = issue ? idx : mux_sel_q;
  assign bus.add_sub = issue ? sub_l[idx] : add_sub_q;
  assign bus.add_a   = acc;
  assign bus.acc_out = acc;
  assign bus.done    = (state == DONE);
  // An empty command never raises busy: its single SCAN cycle goes straight to DONE.
  assign bus.busy    = (state == WAIT) || ((state == SCAN) && !empty_l);

`ifdef ACC_TIMEOUT_EN
  localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [WD_W-1:0] wd_cnt;
  logic            err_q;
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  // NOTE: state is updated with non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rem_mask  <= '0;
      sub_l     <= '0;
      empty_l   <= 1'b0;
      acc       <= '0;
      mux_sel_q <= '0;
      add_sub_q <= 1'b0;
`ifdef ACC_TIMEOUT_EN
      wd_cnt    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            rem_mask <= bus.src_mask;
            sub_l    <= bus.sub_mask;
            empty_l  <= (bus.src_mask == '0);
            acc      <= '0;
            state    <= SCAN;
`ifdef ACC_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
          end
        end
        SCAN: begin
          if (issue) begin
            mux_sel_q <= idx;
            add_sub_q <= sub_l[idx];
            state     <= WAIT;
`ifdef ACC_TIMEOUT_EN
            wd_cnt    <= '0;
`endif
          end else begin
            state <= DONE;
          end
        end
        WAIT: begin
          if (bus.add_ack) begin
            acc           <= bus.add_result;
            rem_mask[idx] <= 1'b0;
            state         <= SCAN;
          end
`ifdef ACC_TIMEOUT_EN
          else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
            // Abort: acc keeps the last completed result.
            err_q <= 1'b1;
            state <= DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_poly_accum_ctrl.sv
// Directed bench for poly_accum_ctrl with a latency-programmable mod-q adder model.
// Builds with or without ACC_TIMEOUT_EN; the watchdog scenario follows the macro.
module tb_poly_accum_ctrl;
  localparam int N      = 256;
  localparam int POLY_W = N * 12;
  localparam int Q      = 3329;
  typedef logic [POLY_W-1:0] poly_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  poly_accum_if #(.NUM_SRC(4), .POLY_W(POLY_W)) bus ();

  poly_accum_ctrl #(.NUM_SRC(4), .POLY_W(POLY_W), .TIMEOUT_CYCLES(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input poly_t got, input poly_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (low 48 bits)", tag, got[47:0], exp[47:0]);
    end
  endtask

  function automatic poly_t fill(input int c);
    poly_t p;
    for (int i = 0; i < N; i++) p[i*12 +: 12] = 12'(c);
    return p;
  endfunction

  function automatic poly_t addsub(input poly_t a, input poly_t b, input logic sub);
    poly_t r;
    for (int i = 0; i < N; i++) begin
      int x;
      x = sub ? int'(a[i*12 +: 12]) - int'(b[i*12 +: 12])
              : int'(a[i*12 +: 12]) + int'(b[i*12 +: 12]);
      if (x < 0) x += Q;
      else if (x >= Q) x -= Q;
      r[i*12 +: 12] = 12'(x);
    end
    return r;
  endfunction

  // Adder model: captures operands on add_req, acks lat cycles later (lat=0 never acks).
  // It ignores rst so a late ack can arrive after a reset.
  poly_t src [4];
  int    lat = 1;
  int    dly = 0;
  poly_t res_q = '0;
  logic  force_ack = 1'b0;

  always @(posedge clk) begin
    if (bus.add_req && lat > 0) begin
      dly   <= lat;
      res_q <= addsub(bus.add_a, src[bus.mux_sel], bus.add_sub);
    end else if (dly > 0) begin
      dly <= dly - 1;
    end
  end

  assign bus.add_ack    = (dly == 1) || force_ack;
  assign bus.add_result = res_q;

  int         req_n;
  logic [7:0] req_seq;
  logic [3:0] sub_seq;
  int         done_cyc;
  logic       busy_seen;

  // Cycle 0 is the start cycle; the task returns at the negedge of the done cycle or after budget.
  task automatic run_op(input logic [3:0] sm, input logic [3:0] bm, input int l,
                        input int inj_start, input int inj_ack, input int budget);
    lat = l; req_n = 0; req_seq = '0; sub_seq = '0; done_cyc = -1; busy_seen = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.src_mask = sm; bus.sub_mask = bm;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      force_ack = 1'b0;
      if (bus.busy) busy_seen = 1'b1;
      if (bus.add_req) begin
        if (req_n < 4) begin
          req_seq[2*req_n +: 2] = bus.mux_sel;
          sub_seq[req_n]        = bus.add_sub;
        end
        req_n++;
      end
      if (bus.done) begin
        done_cyc = n;
        break;
      end
      if (n == inj_start) begin
        bus.start = 1'b1; bus.src_mask = 4'b0001; bus.sub_mask = 4'b1111;
      end
      if (n == inj_ack) force_ack = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_mux_sel"}, poly_t'(bus.mux_sel), '0);
    check({pfx, "_add_req"}, poly_t'(bus.add_req), '0);
    check({pfx, "_add_sub"}, poly_t'(bus.add_sub), '0);
    check({pfx, "_busy"},    poly_t'(bus.busy),    '0);
    check({pfx, "_done"},    poly_t'(bus.done),    '0);
    check({pfx, "_err"},     poly_t'(bus.err),     '0);
    check({pfx, "_acc_out"}, bus.acc_out,          '0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic seen_done;
    logic seen_busy;
    src[0] = fill(100);
    src[1] = fill(1000);
    src[2] = fill(3300);
    src[3] = fill(5);
    rst = 1'b1;
    bus.start = 1'b0; bus.src_mask = '0; bus.sub_mask = '0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: two adds, L=2 -> 100 + 3300 = 3400 mod q = 71
    run_op(4'b0101, 4'b0000, 2, -1, -1, 60);
    check("t1_done_cycle", poly_t'(done_cyc), poly_t'(8));
    check("t1_req_count",  poly_t'(req_n),    poly_t'(2));
    check("t1_mux_order",  poly_t'(req_seq[3:0]), poly_t'(4'b1000));
    check("t1_add_sub",    poly_t'(sub_seq[1:0]), poly_t'(2'b00));
    check("t1_acc_out",    bus.acc_out, fill(71));
    check("t1_busy_in_done", poly_t'(bus.busy), '0);
    @(negedge clk);
    check("t1_done_one_cycle", poly_t'(bus.done), '0);
    check("t1_acc_held",   bus.acc_out, fill(71));

    // 2: single subtract from a cleared accumulator, L=1 -> 0 - 5 = 3324
    run_op(4'b1000, 4'b1000, 1, -1, -1, 60);
    check("t2_done_cycle", poly_t'(done_cyc), poly_t'(4));
    check("t2_req_count",  poly_t'(req_n),    poly_t'(1));
    check("t2_mux_sel",    poly_t'(req_seq[1:0]), poly_t'(2'd3));
    check("t2_add_sub",    poly_t'(sub_seq[0]),   poly_t'(1'b1));
    check("t2_acc_out",    bus.acc_out, fill(3324));

    // 3: empty mask
    run_op(4'b0000, 4'b1111, 1, -1, -1, 60);
    check("t3_done_cycle", poly_t'(done_cyc), poly_t'(2));
    check("t3_req_count",  poly_t'(req_n),    '0);
    check("t3_busy_seen",  poly_t'(busy_seen), '0);
    check("t3_acc_out",    bus.acc_out, '0);

    // 4: all four, L=3; start pulse in WAIT and spurious ack in SCAN are ignored
    // 100 + 1000 + 3300 + 5 = 4405 -> 1076 mod q
    run_op(4'b1111, 4'b0000, 3, 3, 5, 80);
    check("t4_done_cycle", poly_t'(done_cyc), poly_t'(18));
    check("t4_req_count",  poly_t'(req_n),    poly_t'(4));
    check("t4_mux_order",  poly_t'(req_seq),  poly_t'(8'he4));
    check("t4_add_sub",    poly_t'(sub_seq),  '0);
    check("t4_acc_out",    bus.acc_out, fill(1076));

    // 5: reset during WAIT of the second source, then a late ack arrives
    run_op(4'b0101, 4'b0000, 3, -1, -1, 6);
    check("t5_pre_busy",   poly_t'(bus.busy), poly_t'(1'b1));
    check("t5_pre_acc",    bus.acc_out, fill(100));
    rst = 1'b1;
    #1;
    check_reset_outputs("t5_rst");
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    seen_busy = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
      if (bus.busy || bus.add_req) seen_busy = 1'b1;
    end
    check("t5_no_done",    poly_t'(seen_done), '0);
    check("t5_stays_idle", poly_t'(seen_busy), '0);
    check("t5_acc_zero",   bus.acc_out, '0);

`ifdef ACC_TIMEOUT_EN
    // 6: adder never acks -> abort after 64 WAIT cycles, done at 2 + 64
    run_op(4'b0001, 4'b0000, 0, -1, -1, 100);
    check("t6_done_cycle", poly_t'(done_cyc), poly_t'(66));
    check("t6_err",        poly_t'(bus.err),  poly_t'(1'b1));
    check("t6_acc_out",    bus.acc_out, '0);
    @(negedge clk);
    @(negedge clk);
    check("t6_err_sticky", poly_t'(bus.err),  poly_t'(1'b1));
    run_op(4'b0001, 4'b0000, 1, -1, -1, 60);
    check("t6_next_done",  poly_t'(done_cyc), poly_t'(4));
    check("t6_err_cleared", poly_t'(bus.err), '0);
    check("t6_next_acc",   bus.acc_out, fill(100));
`else
    // 6: without the watchdog WAIT lasts indefinitely
    run_op(4'b0001, 4'b0000, 0, -1, -1, 100);
    check("t6_no_done",    poly_t'(done_cyc), poly_t'(-1));
    check("t6_still_busy", poly_t'(bus.busy), poly_t'(1'b1));
    check("t6_err_zero",   poly_t'(bus.err),  '0);
    rst = 1'b1;
    #1;
    check("t6_rst_busy",   poly_t'(bus.busy), '0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
